bconv_ex_sched: RTL and testbench
=================================

Name: bconv_ex_sched

Overview:
- Control-only scheduler that shares one fastBConvEx_BBa_to_q-style base-conversion unit (B∪Ba → q) between NUM_REQ requesters, e.g. the c0/c1/c2 tensor components and the key-switch path.
- Arbitrates requests and drives the converter's in_valid plus an input-mux select.
- Tracks in-flight conversions in a tag FIFO and routes each converter out_valid back to the requester that issued it.
- Provides a watchdog so that a lost completion does not hang the multiply pipeline.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_INFLIGHT, 2, maximum conversions outstanding in the converter (1..8); tag FIFO depth.
- MIN_GAP, 1, minimum cycles between consecutive conv_in_valid pulses (1 = back-to-back allowed).
- TIMEOUT_CYCLES, 64, cycles the oldest outstanding conversion may wait for conv_out_valid before the error state is entered.
- TAG_W, $clog2(NUM_REQ) (min 1), width of the requester index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held with its input poly stable until accepted.
- req_ready  out  NUM_REQ  one-hot grant; high in the acceptance cycle only.
- conv_in_valid  out  1  start pulse to the converter.
- conv_sel  out  TAG_W  index driving the external input_RNSpoly mux; valid when conv_in_valid=1.
- conv_out_valid  in  1  converter completion, aligned with its output poly.
- rsp_valid  out  NUM_REQ  one-hot completion strobe to the owning requester.
- rsp_tag  out  TAG_W  owner index of the current completion.
- inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding-conversion count.
- busy  out  1  inflight != 0.
- err_timeout  out  1  sticky; set on watchdog expiry.
- err_spurious  out  1  sticky; set on conv_out_valid with no outstanding conversion.
- err_clear  in  1  clears both error flags and flushes state.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM = RUN; inflight=0; tag FIFO empty; round-robin pointer=0; gap counter=0; watchdog=0; err_*=0.
  - All outputs low.
- FSM states: RUN and ERR.
  - RUN→ERR when the watchdog reaches TIMEOUT_CYCLES.
  - RUN→ERR on spurious completion.
  - ERR→RUN on err_clear.
  - err_clear in RUN also performs the clear action.
- Issue condition, all combinational in the same cycle:
  - Requires: state=RUN, any req_valid, gap counter expired, and (inflight<MAX_INFLIGHT or conv_out_valid popping a valid entry this cycle).
  - On issue: req_ready[g]=1, conv_in_valid=1, conv_sel=g.
  - Same edge: push g into the tag FIFO and advance the pointer to g+1 mod NUM_REQ.
  - Zero-cycle accept; no other output is asserted in that cycle.
- Arbitration: round-robin starting at the pointer. A lone requester may win on consecutive eligible cycles.
- Gap counter: loaded with MIN_GAP-1 on issue; issue is blocked while it is nonzero.
- Completion:
  - conv_out_valid with FIFO non-empty: rsp_tag=FIFO head and rsp_valid=onehot(head) combinationally in the same cycle; pop at the edge.
  - rsp_valid is never registered, so it stays aligned with the converter data.
- Simultaneous issue and completion: push and pop at the same edge; inflight unchanged; legal at inflight=MAX_INFLIGHT.
- Spurious completion (conv_out_valid with FIFO empty): rsp_valid stays 0; err_spurious=1; enter ERR.
- Watchdog:
  - Counts while inflight>0.
  - Resets to 0 on every pop and whenever inflight=0.
  - At TIMEOUT_CYCLES: err_timeout=1, enter ERR.
- ERR state:
  - No grants; req_ready=0.
  - Completions still route normally while the FIFO is non-empty.
  - Completions with the FIFO empty do not set err_spurious again.
- err_clear (one cycle): flush FIFO, inflight=0, watchdog=0, gap=0, err_*=0, pointer kept.
  - No issue in the clear cycle.
  - A completion arriving in the clear cycle is dropped.
- Counter widths: inflight saturates logically at MAX_INFLIGHT; issue gating guarantees no overflow. FIFO pointers wrap mod MAX_INFLIGHT.

Optional Feature:
- Macro: BCONV_SCHED_PRIO0_EN.
- Defined: requester 0 has absolute priority. When req_valid[0] is high and issue is allowed it always wins. The remaining requesters round-robin among themselves, and the pointer skips index 0.
- Undefined: pure round-robin across all NUM_REQ requesters.

Test Plan:
- Single request: reset, req_valid=3'b010 at cycle 2 → req_ready=3'b010, conv_in_valid=1, conv_sel=1 at cycle 2. Completion at cycle 9 → rsp_valid=3'b010, rsp_tag=1; inflight 1→0.
- Fairness: req_valid=3'b111 held, MAX_INFLIGHT=2, completions 4 cycles after each issue → grant order 0,1,2,0,1,2. inflight never exceeds 2.
- Full plus simultaneous: inflight=2 and conv_out_valid with req_valid pending in the same cycle → issue occurs, one pop, inflight stays 2. Response tags come out in issue order.
- MIN_GAP=3 with continuous requests → conv_in_valid pulses exactly 3 cycles apart.
- Timeout: TIMEOUT_CYCLES=64, issue and never complete → err_timeout=1 at 64 cycles after issue, req_ready=0 thereafter. err_clear → inflight=0, next request granted the following cycle.
- Spurious completion with inflight=0 → err_spurious=1, rsp_valid=0. Asynchronous reset mid-flight (inflight=2) → all outputs 0 immediately.

Source files
------------

// File: rtl/bconv_ex_sched.sv
// Shared B∪Ba->q base-conversion scheduler: arbitration, in-flight tag FIFO,
// completion routing and watchdog. Optional BCONV_SCHED_PRIO0_EN: requester 0 wins.
module bconv_ex_sched #(
  parameter int NUM_REQ        = 3,
  parameter int MAX_INFLIGHT   = 2,
  parameter int MIN_GAP        = 1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              conv_in_valid,
  output logic [TAG_W-1:0]                  conv_sel,
  input  logic                              conv_out_valid,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [TAG_W-1:0]                  rsp_tag,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              busy,
  output logic                              err_timeout,
  output logic                              err_spurious,
  input  logic                              err_clear
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_ERR = 1'b1;

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [TAG_W-1:0] tag_q [MAX_INFLIGHT];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0] rr_q, rr_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic             eto_q, eto_d;
  logic             esp_q, esp_d;

  logic             found;
  logic [TAG_W-1:0] gidx;
  logic [TAG_W-1:0] rr_nxt;
  logic [TAG_W-1:0] head;
  logic             empty;
  logic             pop;
  logic             spurious;
  logic             issue;
  logic             waiting;
  int               arb_j;
  int               arb_b;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (cnt_q == '0);
  assign head  = tag_q[rd_q];

  // Completions route even in ERR; a completion in the clear cycle is dropped.
  assign pop = conv_out_valid & ~empty & ~err_clear & ~reset;

  assign spurious = conv_out_valid & empty & ~err_clear
                  & (state_q == S_RUN);

  assign waiting = ~empty & ~pop;

`ifdef BCONV_SCHED_PRIO0_EN
  // Requester 0 wins outright; the rest rotate over 1..NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    arb_j = 0;
    arb_b = (rr_q == '0) ? 1 : int'(rr_q);
    if (req_valid[0]) begin
      found = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REQ - 1; i++) begin
        arb_j = 1 + ((arb_b - 1 + i) % (NUM_REQ - 1));
        if (!found && req_valid[arb_j]) begin
          found = 1'b1;
          gidx  = TAG_W'(arb_j);
        end
      end
    end
    if (gidx == '0)
      rr_nxt = rr_q;
    else if (gidx == TAG_W'(NUM_REQ - 1))
      rr_nxt = TAG_W'(1);
    else
      rr_nxt = gidx + 1'b1;
  end
`else
  // Round-robin over all requesters starting at the pointer.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    arb_j = 0;
    arb_b = int'(rr_q);
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_j = (arb_b + i) % NUM_REQ;
      if (!found && req_valid[arb_j]) begin
        found = 1'b1;
        gidx  = TAG_W'(arb_j);
      end
    end
    if (gidx == TAG_W'(NUM_REQ - 1))
      rr_nxt = '0;
    else
      rr_nxt = gidx + 1'b1;
  end
`endif

  // A slot freed by this cycle's pop can be reused in the same cycle.
  assign issue = (state_q == S_RUN) & ~err_clear & ~reset & found
               & (gap_q == '0)
               & ((cnt_q < CW'(MAX_INFLIGHT)) | pop);

  // Zero-cycle grant and unregistered completion strobe.
  always_comb begin
    req_ready     = issue ? (ONE << gidx) : '0;
    conv_in_valid = issue;
    conv_sel      = issue ? gidx : '0;
    rsp_valid     = pop ? (ONE << head) : '0;
    rsp_tag       = pop ? head : '0;
  end

  assign inflight     = cnt_q;
  assign busy         = ~empty;
  assign err_timeout  = eto_q;
  assign err_spurious = esp_q;

  // Next-state for FIFO, pacing, watchdog and error FSM.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    eto_d   = eto_q;
    esp_d   = esp_q;
    if (err_clear) begin
      state_d = S_RUN;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
      gap_d   = '0;
      wd_d    = '0;
      eto_d   = 1'b0;
      esp_d   = 1'b0;
    end else begin
      if (pop)
        rd_d = ptr_inc(rd_q);
      if (issue) begin
        wr_d  = ptr_inc(wr_q);
        rr_d  = rr_nxt;
        gap_d = GW'(MIN_GAP - 1);
      end else if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end
      unique case ({issue, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (waiting) begin
        if (wd_q < WW'(TIMEOUT_CYCLES))
          wd_d = wd_q + 1'b1;
      end else begin
        wd_d = '0;
      end
      if (spurious) begin
        esp_d   = 1'b1;
        state_d = S_ERR;
      end
      if ((state_q == S_RUN) && waiting
          && (wd_q == WW'(TIMEOUT_CYCLES - 1))) begin
        eto_d   = 1'b1;
        state_d = S_ERR;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      wd_q    <= '0;
      eto_q   <= 1'b0;
      esp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      eto_q   <= eto_d;
      esp_q   <= esp_d;
    end
  end

  // Tag storage: owner of each outstanding conversion in issue order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_INFLIGHT; i++)
        tag_q[i] <= '0;
    end else if (issue) begin
      tag_q[wr_q] <= gidx;
    end
  end

endmodule

// File: tb/tb_bconv_ex_sched.sv
// Bench for bconv_ex_sched: two instances (MIN_GAP 1 and 3) checked every
// cycle against a queue-based reference model; directed plus random stimulus.
module tb_bconv_ex_sched;

  localparam int N  = 3;
  localparam int MX = 2;
  localparam int T  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req_valid = '0;
  logic       conv_out_valid = 1'b0;
  logic       err_clear = 1'b0;

  logic [2:0] rdy  [2];
  logic       civ  [2];
  logic [1:0] sel  [2];
  logic [2:0] rspv [2];
  logic [1:0] rspt [2];
  logic [1:0] infl [2];
  logic       bsy  [2];
  logic       eto  [2];
  logic       esp  [2];

  int n_chk = 0;
  int n_err = 0;

  int MG [2] = '{1, 3};
  int q  [2][$];
  int ptr [2];
  int gap [2];
  int age [2];
  bit merr [2];
  bit met  [2];
  bit mes  [2];
  bit last_iss [2];
  int last_g [2];

  always #5 clk = ~clk;

  bconv_ex_sched #(.MIN_GAP(1)) u_g1 (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(rdy[0]), .conv_in_valid(civ[0]), .conv_sel(sel[0]),
    .conv_out_valid(conv_out_valid), .rsp_valid(rspv[0]),
    .rsp_tag(rspt[0]), .inflight(infl[0]), .busy(bsy[0]),
    .err_timeout(eto[0]), .err_spurious(esp[0]), .err_clear(err_clear)
  );

  bconv_ex_sched #(.MIN_GAP(3)) u_g3 (
    .clk(clk), .reset(reset), .req_valid(req_valid),
    .req_ready(rdy[1]), .conv_in_valid(civ[1]), .conv_sel(sel[1]),
    .conv_out_valid(conv_out_valid), .rsp_valid(rspv[1]),
    .rsp_tag(rspt[1]), .inflight(infl[1]), .busy(bsy[1]),
    .err_timeout(eto[1]), .err_spurious(esp[1]), .err_clear(err_clear)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      ptr[k] = 0; gap[k] = 0; age[k] = 0;
      merr[k] = 0; met[k] = 0; mes[k] = 0;
      last_iss[k] = 0; last_g[k] = -1;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s[%0d]", tag, k),
          int'({rdy[k], civ[k], sel[k], rspv[k], rspt[k],
                infl[k], bsy[k], eto[k], esp[k]}), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0;
    conv_out_valid = 1'b0; err_clear = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    chk_zero("rst_out");
    reset = 1'b0;
  endtask

  // One clock: drive, compare against the model, then advance the model.
  task automatic cycle(input logic [2:0] rv, input bit cov, input bit clr);
    @(negedge clk);
    req_valid = rv; conv_out_valid = cov; err_clear = clr;
    #1;
    for (int k = 0; k < 2; k++) begin
      int sz, g, prev;
      bit pop, can, e0;
      string s;
      s = $sformatf("[%0d]", k);
      sz = q[k].size();
      pop = cov && sz > 0 && !clr;
      g = -1;
      for (int i = 0; i < N; i++)
        if (g < 0 && rv[(ptr[k] + i) % N]) g = (ptr[k] + i) % N;
      can = !merr[k] && !clr && g >= 0 && gap[k] == 0 && (sz < MX || pop);
      chk({"ready", s}, int'(rdy[k]), can ? (1 << g) : 0);
      chk({"in_valid", s}, int'(civ[k]), int'(can));
      chk({"sel", s}, int'(sel[k]), can ? g : 0);
      chk({"rsp_valid", s}, int'(rspv[k]), pop ? (1 << q[k][0]) : 0);
      chk({"rsp_tag", s}, int'(rspt[k]), pop ? q[k][0] : 0);
      chk({"inflight", s}, int'(infl[k]), sz);
      chk({"busy", s}, int'(bsy[k]), int'(sz > 0));
      chk({"err_timeout", s}, int'(eto[k]), int'(met[k]));
      chk({"err_spurious", s}, int'(esp[k]), int'(mes[k]));
      last_iss[k] = can;
      last_g[k] = g;
      if (clr) begin
        q[k].delete();
        gap[k] = 0; age[k] = 0;
        merr[k] = 0; met[k] = 0; mes[k] = 0;
      end else begin
        e0 = merr[k];
        prev = age[k];
        if (cov && sz == 0 && !e0) begin mes[k] = 1; merr[k] = 1; end
        if (pop) void'(q[k].pop_front());
        if (can) begin
          q[k].push_back(g);
          ptr[k] = (g + 1) % N;
          gap[k] = MG[k] - 1;
        end else if (gap[k] > 0) begin
          gap[k]--;
        end
        if (sz > 0 && !pop) begin
          if (age[k] < T) age[k]++;
          if (!e0 && prev == T - 1) begin met[k] = 1; merr[k] = 1; end
        end else begin
          age[k] = 0;
        end
      end
    end
  endtask

  initial begin
    int ord[$];
    int tq[$];
    int tg[$];
    int exp_ord[6];
    int first;
    exp_ord = '{0, 1, 2, 0, 1, 2};
    model_reset();

    // Single request at cycle 2, completion at cycle 9.
    do_reset();
    cycle(3'b000, 0, 0);
    cycle(3'b000, 0, 0);
    cycle(3'b010, 0, 0);
    chk("single_ready", int'(rdy[0]), 2);
    chk("single_sel", int'(sel[0]), 1);
    for (int c = 3; c < 9; c++) cycle(3'b000, 0, 0);
    chk("single_infl1", int'(infl[0]), 1);
    cycle(3'b000, 1, 0);
    chk("single_rsp", int'(rspv[0]), 2);
    chk("single_tag", int'(rspt[0]), 1);
    cycle(3'b000, 0, 0);
    chk("single_infl0", int'(infl[0]), 0);

    // Fairness with completions 4 cycles after each issue.
    do_reset();
    for (int c = 0; c < 30; c++) begin
      bit cv;
      cv = tq.size() > 0 && c == tq[0] + 4;
      if (cv) void'(tq.pop_front());
      cycle(3'b111, cv, 0);
      if (c == 4) chk("simul_issue", int'(civ[0]), 1);
      if (c == 5) chk("simul_infl", int'(infl[0]), 2);
      chk("fair_max", int'(infl[0] <= 2), 1);
      if (last_iss[0]) begin
        ord.push_back(last_g[0]);
        tq.push_back(c);
      end
    end
    for (int i = 0; i < 6; i++)
      chk("fair_order", (i < ord.size()) ? ord[i] : -1, exp_ord[i]);

    // MIN_GAP=3 instance paces issues 3 cycles apart.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cycle(3'b111, q[1].size() > 0, 0);
      if (last_iss[1]) tg.push_back(c);
    end
    for (int i = 1; i < 5; i++)
      chk("gap3", (i < tg.size()) ? tg[i] - tg[i-1] : -1, 3);

    // Watchdog expiry, blocked grants, then clear.
    do_reset();
    cycle(3'b001, 0, 0);
    first = -1;
    for (int i = 1; i <= 80; i++) begin
      cycle(3'b000, 0, 0);
      if (first < 0 && eto[0]) first = i;
    end
    chk("to_cycle", first, T + 1);
    cycle(3'b111, 0, 0);
    chk("to_noready", int'(rdy[0]), 0);
    cycle(3'b000, 0, 1);
    cycle(3'b001, 0, 0);
    chk("clr_infl", int'(infl[0]), 0);
    chk("clr_err", int'(eto[0]), 0);
    chk("clr_grant", int'(rdy[0]), 1);

    // Spurious completion, then asynchronous reset mid-flight.
    do_reset();
    cycle(3'b000, 1, 0);
    chk("spur_rsp", int'(rspv[0]), 0);
    cycle(3'b000, 0, 0);
    chk("spur_flag", int'(esp[0]), 1);
    cycle(3'b000, 0, 1);
    cycle(3'b001, 0, 0);
    cycle(3'b010, 0, 0);
    @(negedge clk);
    chk("pre_rst_infl", int'(infl[0]), 2);
    req_valid = 3'b111; conv_out_valid = 1'b1; reset = 1'b1;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0; req_valid = '0; conv_out_valid = 1'b0;

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] rv;
      bit cv, cl;
      rv = 3'($urandom_range(0, 7));
      if (q[0].size() > 0)
        cv = ($urandom_range(0, 2) == 0);
      else
        cv = ($urandom_range(0, 40) == 0);
      cl = ($urandom_range(0, 80) == 0);
      cycle(rv, cv, cl);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
